// File: rtl/mode_counter.sv
// Parametrised synchronous counter with up, down, ping-pong and one-shot modes.
// Provides count enable, parallel load, synchronous clear, terminal-count and done status.
module mode_counter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] cout,
   output logic             dir,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH:0]   MaxExt = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH-1:0] MaxW   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH:0]   One    = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic {StUp, StDown} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;

   // One spare bit keeps the increment from wrapping before the MAX_VAL compare.
   logic [WIDTH:0]   cnt_ext, inc_ext, dec_ext;
   logic [WIDTH-1:0] load_clamped;

   assign cnt_ext      = {1'b0, cnt_q};
   assign inc_ext      = cnt_ext + One;
   assign dec_ext      = cnt_ext - One;
   assign load_clamped = ({1'b0, load_val} > MaxExt) ? MaxW : load_val;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StUp;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (clear) begin
         cnt_d   = '0;
         done_d  = 1'b0;
         state_d = (mode == 2'b01) ? StDown : StUp;
      end else if (load) begin
         cnt_d  = load_clamped;
         done_d = 1'b0;
         unique case (mode)
            2'b00, 2'b11: state_d = StUp;
            2'b01:        state_d = StDown;
            default:      state_d = state_q;
         endcase
      end else if (en) begin
         unique case (mode)
            2'b00: begin
               state_d = StUp;
               done_d  = 1'b0;
               if (cnt_ext == MaxExt) begin
                  cnt_d = '0;
                  tc_d  = 1'b1;
               end else begin
                  cnt_d = inc_ext[WIDTH-1:0];
               end
            end
            2'b01: begin
               state_d = StDown;
               done_d  = 1'b0;
               if (cnt_q == '0) begin
                  cnt_d = MaxW;
                  tc_d  = 1'b1;
               end else begin
                  cnt_d = dec_ext[WIDTH-1:0];
               end
            end
            2'b10: begin
               done_d = 1'b0;
               if (state_q == StUp) begin
                  if (cnt_ext == MaxExt) begin
                     cnt_d   = dec_ext[WIDTH-1:0];
                     state_d = StDown;
                     tc_d    = 1'b1;
                  end else begin
                     cnt_d = inc_ext[WIDTH-1:0];
                  end
               end else begin
                  if (cnt_q == '0) begin
                     cnt_d   = One[WIDTH-1:0];
                     state_d = StUp;
                     tc_d    = 1'b1;
                  end else begin
                     cnt_d = dec_ext[WIDTH-1:0];
                  end
               end
            end
            default: begin
               state_d = StUp;
               // Only the step that lands on MAX_VAL completes the shot.
               if (cnt_ext < MaxExt) begin
                  cnt_d = inc_ext[WIDTH-1:0];
                  if (inc_ext == MaxExt) begin
                     done_d = 1'b1;
                     tc_d   = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      cout = cnt_q;
      dir  = (state_q == StDown);
      tc   = tc_q;
      done = done_q;
   end

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: four instances with different WIDTH/MAX_VAL
// share one stimulus stream and are compared every cycle against an integer model.
module tb_mode_counter;

   logic       clk = 1'b0;
   logic       reset, en, clear, load;
   logic [8:0] load_val;
   logic [1:0] mode;

   logic [7:0] cout_a, cout_b, cout_c;
   logic [8:0] cout_d;
   logic       dir_a, dir_b, dir_c, dir_d;
   logic       tc_a, tc_b, tc_c, tc_d;
   logic       done_a, done_b, done_c, done_d;

   int checks = 0;
   int errors = 0;

   int m_max[4]   = '{255, 9, 3, 255};
   int m_width[4] = '{8, 8, 8, 9};
   int m_cnt[4], m_dir[4], m_tc[4], m_done[4];

   logic [8:0] obs_cnt[4];
   logic       obs_dir[4], obs_tc[4], obs_done[4];

   always #5 clk = ~clk;

   mode_counter #(.WIDTH(8), .MAX_VAL(255)) dut_a (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val[7:0]),
      .mode(mode), .cout(cout_a), .dir(dir_a), .tc(tc_a), .done(done_a));
   mode_counter #(.WIDTH(8), .MAX_VAL(9)) dut_b (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val[7:0]),
      .mode(mode), .cout(cout_b), .dir(dir_b), .tc(tc_b), .done(done_b));
   mode_counter #(.WIDTH(8), .MAX_VAL(3)) dut_c (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val[7:0]),
      .mode(mode), .cout(cout_c), .dir(dir_c), .tc(tc_c), .done(done_c));
   mode_counter #(.WIDTH(9), .MAX_VAL(255)) dut_d (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val),
      .mode(mode), .cout(cout_d), .dir(dir_d), .tc(tc_d), .done(done_d));

   assign obs_cnt[0] = {1'b0, cout_a};
   assign obs_cnt[1] = {1'b0, cout_b};
   assign obs_cnt[2] = {1'b0, cout_c};
   assign obs_cnt[3] = cout_d;
   assign obs_dir  = '{dir_a, dir_b, dir_c, dir_d};
   assign obs_tc   = '{tc_a, tc_b, tc_c, tc_d};
   assign obs_done = '{done_a, done_b, done_c, done_d};

   // Ping-pong is modelled as a bounce: a step that would leave 0..max reverses direction.
   task automatic model_edge();
      for (int i = 0; i < 4; i++) begin
         int lv, nxt;
         lv = int'(load_val) % (1 << m_width[i]);
         if (!reset) begin
            m_cnt[i] = 0; m_dir[i] = 0; m_tc[i] = 0; m_done[i] = 0;
         end else if (clear) begin
            m_cnt[i] = 0; m_done[i] = 0; m_tc[i] = 0; m_dir[i] = (mode == 2'd1) ? 1 : 0;
         end else if (load) begin
            m_cnt[i] = (lv > m_max[i]) ? m_max[i] : lv;
            m_done[i] = 0; m_tc[i] = 0;
            if (mode != 2'd2) m_dir[i] = (mode == 2'd1) ? 1 : 0;
         end else if (!en) begin
            m_tc[i] = 0;
         end else begin
            case (mode)
               2'd0: begin
                  m_tc[i] = (m_cnt[i] == m_max[i]) ? 1 : 0;
                  m_cnt[i] = (m_cnt[i] + 1) % (m_max[i] + 1);
                  m_dir[i] = 0; m_done[i] = 0;
               end
               2'd1: begin
                  m_tc[i] = (m_cnt[i] == 0) ? 1 : 0;
                  m_cnt[i] = (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
                  m_dir[i] = 1; m_done[i] = 0;
               end
               2'd2: begin
                  m_done[i] = 0; m_tc[i] = 0;
                  nxt = m_cnt[i] + (m_dir[i] ? -1 : 1);
                  if (nxt < 0 || nxt > m_max[i]) begin
                     m_dir[i] = 1 - m_dir[i];
                     nxt = m_cnt[i] + (m_dir[i] ? -1 : 1);
                     m_tc[i] = 1;
                  end
                  m_cnt[i] = nxt;
               end
               default: begin
                  m_dir[i] = 0; m_tc[i] = 0;
                  if (m_cnt[i] < m_max[i]) begin
                     m_cnt[i]++;
                     if (m_cnt[i] == m_max[i]) begin
                        m_tc[i] = 1; m_done[i] = 1;
                     end
                  end
               end
            endcase
         end
      end
   endtask

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s.cout[%0d]", tag, i), int'(obs_cnt[i]), m_cnt[i]);
         chk($sformatf("%s.dir[%0d]", tag, i), int'(obs_dir[i]), m_dir[i]);
         chk($sformatf("%s.tc[%0d]", tag, i), int'(obs_tc[i]), m_tc[i]);
         chk($sformatf("%s.done[%0d]", tag, i), int'(obs_done[i]), m_done[i]);
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; mode = 2'd0;
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0; m_dir[i] = 0; m_tc[i] = 0; m_done[i] = 0;
      end
      repeat (3) step("reset");
      chk("reset_cout_a", int'(cout_a), 0);

      // Up-wrap through the full 8-bit range.
      reset = 1'b1; en = 1'b1; mode = 2'd0;
      repeat (256) step("up");
      chk("wrap_cout_a", int'(cout_a), 0);
      chk("wrap_tc_a", int'(tc_a), 1);
      repeat (10) step("up");

      // Down-wrap from a clear.
      clear = 1'b1; mode = 2'd1; step("down_clr");
      clear = 1'b0;
      step("down");
      chk("down_first_b", int'(cout_b), 9);
      chk("down_tc_b", int'(tc_b), 1);
      repeat (11) step("down");

      // Ping-pong from reset.
      reset = 1'b0; mode = 2'd2; step("pp_rst");
      reset = 1'b1;
      repeat (3) step("pp");
      step("pp");
      chk("pp_turn_c", int'(cout_c), 2);
      chk("pp_turn_dir_c", int'(dir_c), 1);
      repeat (12) step("pp");

      // One-shot from a load.
      mode = 2'd3; load_val = 9'd250; load = 1'b1; en = 1'b0; step("os_load");
      load = 1'b0; en = 1'b1;
      repeat (5) step("os");
      chk("os_done_a", int'(done_a), 1);
      chk("os_tc_a", int'(tc_a), 1);
      repeat (5) step("os_hold");
      chk("os_hold_a", int'(cout_a), 255);

      // Priority and clamp.
      load = 1'b1; clear = 1'b1; load_val = 9'd100; step("prio");
      chk("prio_cout_a", int'(cout_a), 0);
      clear = 1'b0; load_val = 9'd300; mode = 2'd0; step("clamp");
      chk("clamp_cout_d", int'(cout_d), 255);
      load = 1'b0; en = 1'b0;
      repeat (3) step("hold");

      // Reset mid-count while ping-pong is heading down.
      mode = 2'd1; load = 1'b1; load_val = 9'd20; step("mid_load");
      load = 1'b0; en = 1'b1; mode = 2'd2;
      repeat (3) step("mid_down");
      chk("mid_cout_a", int'(cout_a), 17);
      reset = 1'b0; step("mid_rst");
      reset = 1'b1;
      repeat (4) step("mid_resume");

      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(0, 49) != 0);
         clear    = ($urandom_range(0, 19) == 0);
         load     = ($urandom_range(0, 14) == 0);
         en       = ($urandom_range(0, 3) != 0);
         load_val = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
